// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  localparam int REGW_DEF = 4;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-stage status in, stage enables/flushes/forward selects out
interface pipe_hazard_ctrl_if #(
  parameter int REGW = pipe_ctrl_pkg::REGW_DEF
);
  logic [REGW-1:0] ID_rs1, ID_rs2;
  logic            ID_UsesRs1, ID_UsesRs2;
  logic [REGW-1:0] EX_rs1, EX_rs2, EX_rd;
  logic            EX_RegWrite, EX_MemToReg, EX_BranchTaken;
  logic [REGW-1:0] MEM_rd;
  logic            MEM_RegWrite, MEM_MemToReg, MEM_MemWrite;
  logic [REGW-1:0] WB_rd;
  logic            WB_RegWrite;
  logic            mem_ready;

  logic            IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic            IF_ID_flush, ID_EX_flush;
  logic            mem_req;
  logic [1:0]      FwdA, FwdB;
  logic            mem_err;
  logic [15:0]     stall_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_UsesRs1, ID_UsesRs2,
    output EX_rs1, EX_rs2, EX_rd, EX_RegWrite, EX_MemToReg, EX_BranchTaken,
    output MEM_rd, MEM_RegWrite, MEM_MemToReg, MEM_MemWrite,
    output WB_rd, WB_RegWrite, mem_ready,
    input  IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
    input  IF_ID_flush, ID_EX_flush, mem_req, FwdA, FwdB, mem_err, stall_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_UsesRs1, ID_UsesRs2,
    input  EX_rs1, EX_rs2, EX_rd, EX_RegWrite, EX_MemToReg, EX_BranchTaken,
    input  MEM_rd, MEM_RegWrite, MEM_MemToReg, MEM_MemWrite,
    input  WB_rd, WB_RegWrite, mem_ready,
    output IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
    output IF_ID_flush, ID_EX_flush, mem_req, FwdA, FwdB, mem_err, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// rtl/pipe_hazard_ctrl_fwd_unit.sv - operand bypass select for one EX source register
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REGW = REGW_DEF
) (
  input  logic [REGW-1:0] i_ex_rs,
  input  logic [REGW-1:0] i_mem_rd,
  input  logic            i_mem_we,
  input  logic [REGW-1:0] i_wb_rd,
  input  logic            i_wb_we,
  output logic [1:0]      o_fwd
);

  logic w_hit_mem, w_hit_wb;

  // r0 is hardwired zero, so a write to it must never be bypassed
  assign w_hit_mem = i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs);
  assign w_hit_wb  = i_wb_we  && (i_wb_rd  != '0) && (i_wb_rd  == i_ex_rs);

  assign o_fwd = w_hit_mem ? FWD_MEM : (w_hit_wb ? FWD_WB : FWD_RF);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward control for a 5-stage pipeline
// with a data-memory wait state and sticky timeout error.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int REGW        = REGW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_hazard_ctrl_if.slave    bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_wait_cnt, w_wait_next;
  logic            r_mem_err;
  logic [15:0]     r_stall_cnt;

  logic            w_mem_acc, w_load_use, w_run_rules;
  logic            w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic            w_if_id_flush, w_id_ex_flush, w_mem_req;
  logic [1:0]      w_fwd_a, w_fwd_b;

  assign w_mem_acc = bus.MEM_MemToReg | bus.MEM_MemWrite;

  assign w_load_use = bus.EX_MemToReg && bus.EX_RegWrite && (bus.EX_rd != '0) &&
                      ((bus.ID_UsesRs1 && (bus.ID_rs1 == bus.EX_rd)) ||
                       (bus.ID_UsesRs2 && (bus.ID_rs2 == bus.EX_rd)));

  always_comb begin
    w_next        = r_state;
    w_wait_next   = r_wait_cnt;
    w_run_rules   = 1'b0;
    w_if_id_en    = 1'b1;
    w_id_ex_en    = 1'b1;
    w_ex_mem_en   = 1'b1;
    w_mem_wb_en   = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_mem_req     = w_mem_acc;

    case (r_state)
      S_RUN: begin
        if (w_mem_acc && !bus.mem_ready) begin
          w_next      = S_MEM_WAIT;
          w_wait_next = CW'(1);
        end else begin
          w_run_rules = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (!bus.mem_ready) begin
          if (r_wait_cnt == CW'(MEM_TIMEOUT)) begin
            w_next = S_ERROR;
          end else begin
            w_wait_next = r_wait_cnt + CW'(1);
          end
        end else begin
          w_next      = S_RUN;
          w_wait_next = '0;
          w_run_rules = 1'b1;
        end
      end
      S_ERROR: begin
        w_mem_req = 1'b0;
      end
      default: begin
        w_next = S_RUN;
      end
    endcase

    // Freeze outranks branch flush, which outranks the load-use bubble
    if (!w_run_rules) begin
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
    end else if (bus.EX_BranchTaken) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      w_if_id_en    = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      if (w_next == S_ERROR) begin
        r_mem_err <= 1'b1;
      end
      if (!w_if_id_en && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  fwd_unit #(.REGW(REGW)) u_fwd_a (
    .i_ex_rs  (bus.EX_rs1),
    .i_mem_rd (bus.MEM_rd),
    .i_mem_we (bus.MEM_RegWrite),
    .i_wb_rd  (bus.WB_rd),
    .i_wb_we  (bus.WB_RegWrite),
    .o_fwd    (w_fwd_a)
  );

  fwd_unit #(.REGW(REGW)) u_fwd_b (
    .i_ex_rs  (bus.EX_rs2),
    .i_mem_rd (bus.MEM_rd),
    .i_mem_we (bus.MEM_RegWrite),
    .i_wb_rd  (bus.WB_rd),
    .i_wb_we  (bus.WB_RegWrite),
    .o_fwd    (w_fwd_b)
  );

  assign bus.IF_ID_en    = w_if_id_en;
  assign bus.ID_EX_en    = w_id_ex_en;
  assign bus.EX_MEM_en   = w_ex_mem_en;
  assign bus.MEM_WB_en   = w_mem_wb_en;
  assign bus.IF_ID_flush = w_if_id_flush;
  assign bus.ID_EX_flush = w_id_ex_flush;
  assign bus.mem_req     = w_mem_req;
  assign bus.FwdA        = w_fwd_a;
  assign bus.FwdB        = w_fwd_b;
  assign bus.mem_err     = r_mem_err;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pipe_hazard_ctrl_if #(.REGW(4)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .REGW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    bus.ID_rs1 = '0; bus.ID_rs2 = '0; bus.ID_UsesRs1 = 0; bus.ID_UsesRs2 = 0;
    bus.EX_rs1 = '0; bus.EX_rs2 = '0; bus.EX_rd = '0;
    bus.EX_RegWrite = 0; bus.EX_MemToReg = 0; bus.EX_BranchTaken = 0;
    bus.MEM_rd = '0; bus.MEM_RegWrite = 0; bus.MEM_MemToReg = 0; bus.MEM_MemWrite = 0;
    bus.WB_rd = '0; bus.WB_RegWrite = 0; bus.mem_ready = 0;
  endtask

  task automatic set_load_use();
    bus.EX_MemToReg = 1; bus.EX_RegWrite = 1; bus.EX_rd = 4'd3;
    bus.ID_rs1 = 4'd3; bus.ID_UsesRs1 = 1;
  endtask

  function automatic logic [3:0] en4();
    return {bus.IF_ID_en, bus.ID_EX_en, bus.EX_MEM_en, bus.MEM_WB_en};
  endfunction

  function automatic logic [1:0] fl2();
    return {bus.IF_ID_flush, bus.ID_EX_flush};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    clear_in();
    #2;
    chk("reset_en", en4(), 4'hF);
    chk("reset_flush", fl2(), 2'b00);
    chk("reset_stall_cnt", bus.stall_cnt, 16'd0);
    chk("reset_mem_err", bus.mem_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // load-use on r3
    @(negedge clk);
    set_load_use();
    #1;
    chk("lu_en", en4(), 4'b0111);
    chk("lu_flush", fl2(), 2'b01);
    chk("lu_stall_before", bus.stall_cnt, 16'd0);
    @(negedge clk);
    chk("lu_stall_after", bus.stall_cnt, 16'd1);
    clear_in();
    #1;
    chk("lu_released_en", en4(), 4'hF);

    // no stall when the match is on r0 or the operand is unused
    bus.EX_MemToReg = 1; bus.EX_RegWrite = 1; bus.EX_rd = 4'd0;
    bus.ID_rs1 = 4'd0; bus.ID_UsesRs1 = 1;
    #1;
    chk("lu_r0_en", en4(), 4'hF);
    bus.EX_rd = 4'd6; bus.ID_rs2 = 4'd6; bus.ID_UsesRs2 = 0;
    #1;
    chk("lu_unused_en", en4(), 4'hF);
    bus.ID_UsesRs2 = 1;
    #1;
    chk("lu_rs2_en", en4(), 4'b0111);
    clear_in();

    // forwarding
    bus.MEM_rd = 4'd5; bus.MEM_RegWrite = 1; bus.WB_rd = 4'd5; bus.WB_RegWrite = 1;
    bus.EX_rs1 = 4'd5; bus.EX_rs2 = 4'd7;
    #1;
    chk("fwd_a_mem", bus.FwdA, 2'b10);
    chk("fwd_b_none", bus.FwdB, 2'b00);
    bus.MEM_RegWrite = 0; bus.EX_rs2 = 4'd5;
    #1;
    chk("fwd_a_wb", bus.FwdA, 2'b01);
    chk("fwd_b_wb", bus.FwdB, 2'b01);
    bus.EX_rs1 = 4'd0; bus.MEM_rd = 4'd0; bus.WB_rd = 4'd0;
    bus.MEM_RegWrite = 1; bus.WB_RegWrite = 1;
    #1;
    chk("fwd_a_r0", bus.FwdA, 2'b00);
    chk("fwd_en_untouched", en4(), 4'hF);
    clear_in();

    // branch beats load-use
    @(negedge clk);
    set_load_use();
    bus.EX_BranchTaken = 1;
    #1;
    chk("br_lu_en", en4(), 4'hF);
    chk("br_lu_flush", fl2(), 2'b11);
    @(negedge clk);
    chk("br_no_stall_count", bus.stall_cnt, 16'd1);
    clear_in();

    // memory wait: 3 frozen cycles, then ready
    bus.MEM_MemToReg = 1; bus.mem_ready = 0;
    #1;
    chk("mw_c0_en", en4(), 4'h0);
    chk("mw_c0_req", bus.mem_req, 1'b1);
    @(negedge clk);
    set_load_use();
    bus.EX_BranchTaken = 1;
    #1;
    chk("mw_c1_br_en", en4(), 4'h0);
    chk("mw_c1_br_flush", fl2(), 2'b00);
    @(negedge clk);
    #1;
    chk("mw_c2_en", en4(), 4'h0);
    @(negedge clk);
    bus.mem_ready = 1;
    #1;
    chk("mw_ready_en", en4(), 4'hF);
    chk("mw_ready_flush", fl2(), 2'b11);
    @(negedge clk);
    clear_in();
    #1;
    chk("mw_back_run_en", en4(), 4'hF);
    chk("mw_stall_cnt", bus.stall_cnt, 16'd4);

    // timeout: 16 cycles of mem_ready low
    @(negedge clk);
    bus.MEM_MemWrite = 1; bus.mem_ready = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("to_wait%0d_en", k), en4(), 4'h0);
      chk($sformatf("to_wait%0d_err", k), bus.mem_err, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("to_err", bus.mem_err, 1'b1);
    chk("to_err_en", en4(), 4'h0);
    chk("to_err_req", bus.mem_req, 1'b0);
    chk("to_stall_cnt", bus.stall_cnt, 16'd20);
    bus.MEM_MemWrite = 0; bus.mem_ready = 1; bus.EX_BranchTaken = 1;
    #1;
    chk("err_held_en", en4(), 4'h0);
    chk("err_held_flush", fl2(), 2'b00);

    // stall counter saturates while stuck in error
    repeat (65600) @(negedge clk);
    #1;
    chk("sat_stall_cnt", bus.stall_cnt, 16'hFFFF);
    chk("sat_err_sticky", bus.mem_err, 1'b1);

    // asynchronous reset pulse clears the error
    #1;
    rst_n = 1'b0;
    clear_in();
    #1;
    chk("rst_err_clr", bus.mem_err, 1'b0);
    chk("rst_stall_clr", bus.stall_cnt, 16'd0);
    chk("rst_en_run", en4(), 4'hF);
    @(negedge clk) rst_n = 1'b1;

    // reset in the middle of a memory wait
    @(negedge clk);
    bus.MEM_MemToReg = 1; bus.mem_ready = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mw2_stall_cnt", bus.stall_cnt, 16'd2);
    chk("mw2_en", en4(), 4'h0);
    #1;
    rst_n = 1'b0;
    bus.MEM_MemToReg = 0;
    #1;
    chk("mw2_rst_stall", bus.stall_cnt, 16'd0);
    chk("mw2_rst_en", en4(), 4'hF);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("mw2_after_run", en4(), 4'hF);
    @(negedge clk);
    set_load_use();
    #1;
    chk("mw2_lu_en", en4(), 4'b0111);
    @(negedge clk);
    chk("mw2_lu_stall", bus.stall_cnt, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max wait cycles for data-memory ready before error.
REQ-002 Parameter: REGW, 4, register-index width.
REQ-003 clk  in  1  single pipeline clock; all state on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ID_rs1, ID_rs2  in  REGW  source registers of instruction in ID.
REQ-006 ID_UsesRs1, ID_UsesRs2  in  1  ID instruction actually reads rs1/rs2.
REQ-007 EX_rs1, EX_rs2  in  REGW  source registers of instruction in EX.
REQ-008 EX_rd, EX_RegWrite, EX_MemToReg  in  REGW/1/1  EX-stage destination and controls.
REQ-009 MEM_rd, MEM_RegWrite, MEM_MemToReg, MEM_MemWrite  in  REGW/1/1/1  MEM-stage destination and controls.
REQ-010 WB_rd, WB_RegWrite  in  REGW/1  WB-stage destination and write enable.
REQ-011 EX_BranchTaken  in  1  branch resolved taken in EX.
REQ-012 mem_ready  in  1  data memory completes the current MEM access this cycle.
REQ-013 IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en  out  1  pipeline-register load enables.
REQ-014 IF_ID_flush, ID_EX_flush  out  1  load bubble (all controls 0) instead of data.
REQ-015 mem_req  out  1  MEM stage access request to data memory.
REQ-016 FwdA, FwdB  out  2  EX operand select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result.
REQ-017 mem_err  out  1  sticky memory-timeout error.
REQ-018 stall_cnt  out  16  saturating count of cycles with IF_ID_en=0.

Function
REQ-019 FSM states SHALL be RUN, MEM_WAIT, ERROR; reset state RUN.
REQ-020 mem_acc = MEM_MemToReg | MEM_MemWrite; mem_req SHALL equal mem_acc in RUN and MEM_WAIT, 0 in ERROR.
REQ-021 RUN, mem_acc=1, mem_ready=0: all four enables 0, flushes 0, next state MEM_WAIT, wait counter cleared to 1.
REQ-022 MEM_WAIT, mem_ready=0: all enables 0, counter increments; counter==MEM_TIMEOUT with mem_ready=0 SHALL go to ERROR.
REQ-023 MEM_WAIT, mem_ready=1: enables follow RUN rules that cycle, next state RUN (zero extra latency after ready).
REQ-024 ERROR: all enables 0, flushes 0, mem_err=1, held until reset.
REQ-025 Load-use: EX_MemToReg & EX_RegWrite & EX_rd!=0 & ((ID_UsesRs1 & ID_rs1==EX_rd) | (ID_UsesRs2 & ID_rs2==EX_rd)) SHALL give IF_ID_en=0, ID_EX_flush=1, EX_MEM_en=MEM_WB_en=1 for exactly that cycle.
REQ-026 EX_BranchTaken SHALL assert IF_ID_flush=1 and ID_EX_flush=1, all enables 1.
REQ-027 Priority: memory freeze > branch flush > load-use stall; branch and load-use together SHALL produce branch behaviour only.
REQ-028 Idle RUN (no hazard): all enables 1, flushes 0.
REQ-029 Forwarding (combinational): FwdX=10 if MEM_RegWrite & MEM_rd!=0 & MEM_rd==EX_rsX; else 01 if WB_RegWrite & WB_rd!=0 & WB_rd==EX_rsX; else 00.
REQ-030 Register index 0 SHALL never be forwarded or trigger a stall.
REQ-031 Enables/flushes/forward selects SHALL be combinational from state and inputs (same-cycle effect); only state, wait counter, mem_err, stall_cnt are registered.
REQ-032 stall_cnt SHALL increment each cycle IF_ID_en=0 and saturate at 16'hFFFF.

Reset
REQ-033 rst_n low SHALL immediately force state RUN, wait counter 0, mem_err 0, stall_cnt 0, irrespective of clk.
REQ-034 Reset asserted mid-MEM_WAIT SHALL abandon the wait; after release the block SHALL be in RUN.
REQ-035 Combinational outputs during reset SHALL reflect RUN-state rules.

Structure
REQ-036 Package pipe_ctrl_pkg SHALL hold the state enum, FWD_RF/FWD_MEM/FWD_WB constants and REGW default.
REQ-037 Forwarding logic SHALL be sub-module fwd_unit (one instance per operand, or one instance with two outputs).

Verification
REQ-038 EX: load to r3; ID reads r3 -> one cycle IF_ID_en=0, ID_EX_flush=1, stall_cnt 0->1.
REQ-039 MEM_MemToReg=1, mem_ready low 3 cycles then high -> enables 0 for 3 cycles, 1 on ready cycle, state back to RUN.
REQ-040 mem_ready held low 16 cycles with MEM_TIMEOUT=15 -> mem_err=1, enables 0 until rst_n pulse.
REQ-041 MEM_rd=5 & WB_rd=5 both writing, EX_rs1=5 -> FwdA=10; MEM_RegWrite=0 -> FwdA=01; EX_rs1=0 -> FwdA=00.
REQ-042 EX_BranchTaken with simultaneous load-use -> both flushes 1, IF_ID_en=1; with mem stall active -> enables 0, flushes 0.
REQ-043 rst_n low during MEM_WAIT (asynchronous, between edges) -> state RUN, stall_cnt 0 without waiting for clk.
